// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage definitions: reset level, bus widths, IF state encoding.
package if_fetch_pkg;

  localparam logic        RST_ENABLE    = 1'b1;
  localparam int          INST_ADDR_W   = 32;
  localparam int          INST_W        = 32;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  // Bytes per instruction (RV32I, no compressed) and the counter width that
  // holds 0..IF_INST_BYTES inclusive.
  localparam int          IF_INST_BYTES = 4;
  localparam int          CNT_W         = 3;

  typedef enum logic {
    IF_FETCH = 1'b0,
    IF_HOLD  = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_byte_asm.sv
// Collects returning memory bytes into one little-endian instruction word.
// word_next already includes a byte captured this cycle, so the fetch FSM can
// deliver on the same edge the last byte lands.
module if_byte_asm
  import if_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,     // delivery or flush restarts collection
  input  logic              flush,     // arms the one-cycle discard
  input  logic              pending,   // a granted byte returns this cycle
  input  logic [7:0]        rdata,
  output logic              done_next, // final byte is captured this cycle
  output logic [INST_W-1:0] word_next
);

  logic [CNT_W-1:0]                recv_cnt;
  logic                            discard;
  logic                            capture;
  logic [IF_INST_BYTES-1:0][7:0]   bytes_q;
  logic [IF_INST_BYTES-1:0][7:0]   bytes_d;

  // A byte from a grant issued before a flush must not land in the new word.
  assign capture   = pending && !discard && (recv_cnt < CNT_W'(IF_INST_BYTES));
  assign done_next = capture && (recv_cnt == CNT_W'(IF_INST_BYTES - 1));
  assign word_next = bytes_d;

  // Merge the incoming byte into its little-endian lane.
  always_comb begin
    bytes_d = bytes_q;
    if (capture) bytes_d[recv_cnt[1:0]] = rdata;
  end

  // Byte storage, receive counter and discard flag.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      recv_cnt <= '0;
      discard  <= 1'b0;
      bytes_q  <= '0;
    end else begin
      discard <= flush;
      bytes_q <= bytes_d;
      if (clear)        recv_cnt <= '0;
      else if (capture) recv_cnt <= recv_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, streams instruction bytes over the shared
// byte-wide memory port and hands whole words to IF/ID as one-cycle pulses.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                     INST_BYTES = IF_INST_BYTES
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [INST_ADDR_W-1:0] flush_target_i,
  output logic                   mem_req_o,
  output logic [INST_ADDR_W-1:0] mem_addr_o,
  input  logic                   mem_grant_i,
  input  logic [7:0]             mem_rdata_i,
  output logic                   get_inst_o,
  output logic [INST_ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0]      if_inst_o
);

  if_state_e              state;
  logic [INST_ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]       issue_cnt;
  logic                   pending;
  logic                   issue;
  logic                   deliver;
  logic                   done_next;
  logic [INST_W-1:0]      word_next;

  // Request bytes until all of them are issued; never while holding a word.
  // Address is formed in 32 bits so it wraps instead of carrying anywhere.
  assign mem_req_o  = (rst != RST_ENABLE) && (state == IF_FETCH) &&
                      (issue_cnt < CNT_W'(INST_BYTES));
  assign mem_addr_o = (rst == RST_ENABLE) ? ZERO_WORD
                                          : fetch_pc + INST_ADDR_W'(issue_cnt);
  assign issue      = mem_req_o && mem_grant_i;

  // Flush beats both stall and a word completing in the same cycle.
  assign deliver = !flush_i && !stall_i && ((state == IF_HOLD) || done_next);

  if_byte_asm u_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i || deliver),
    .flush     (flush_i),
    .pending   (pending),
    .rdata     (mem_rdata_i),
    .done_next (done_next),
    .word_next (word_next)
  );

  // Fetch FSM: PC, issue counter, in-flight flag and registered IF/ID outputs.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state      <= IF_FETCH;
      fetch_pc   <= RESET_PC;
      issue_cnt  <= '0;
      pending    <= 1'b0;
      get_inst_o <= 1'b0;
      if_pc_o    <= ZERO_WORD;
      if_inst_o  <= ZERO_WORD;
    end else begin
      pending    <= issue;
      get_inst_o <= deliver;
      if (flush_i) begin
        state     <= IF_FETCH;
        fetch_pc  <= flush_target_i;
        issue_cnt <= '0;
      end else if (deliver) begin
        state     <= IF_FETCH;
        if_pc_o   <= fetch_pc;
        if_inst_o <= word_next;
        fetch_pc  <= fetch_pc + INST_ADDR_W'(INST_BYTES);
        issue_cnt <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
        if (done_next && stall_i) state <= IF_HOLD;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: memory responder plus scoreboard. The reference model
// treats the fetch unit as "deliver consecutive instructions from the current
// stream start; granted byte addresses form a contiguous run from that start";
// flush and reset restart the stream. Directed cases pin down cycle timing.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_target_i = '0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_grant_i = 1'b0;
  logic [7:0]  mem_rdata_i = '0;
  logic        get_inst_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .flush_i        (flush_i),
    .flush_target_i (flush_target_i),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_grant_i    (mem_grant_i),
    .mem_rdata_i    (mem_rdata_i),
    .get_inst_o     (get_inst_o),
    .if_pc_o        (if_pc_o),
    .if_inst_o      (if_inst_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        exp_q[$];
  int          dlv_cyc[$];
  logic [7:0]  mem [0:511];
  int          nchk = 0;
  int          nerr = 0;
  int          cyc  = 0;
  int          now  = 0;
  int          base = 0;
  logic        prev_gnt  = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] exp_addr  = '0;
  logic        s_req;
  logic [31:0] s_addr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (a < 32'd512) return mem[a[8:0]];
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  function automatic int dlv_rel(input int i);
    if (i < dlv_cyc.size()) return dlv_cyc[i] - base;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic restart(input logic [31:0] a);
    exp_addr = a;
    exp_q.delete();
    exp_q.push_back('{a, word_at(a)});
  endtask

  // One clock cycle: return the byte granted last cycle, apply this cycle's
  // controls, then check any granted address against the contiguous stream.
  task automatic cycle(input logic r, input logic g, input logic s, input logic f,
                       input logic [31:0] t);
    @(negedge clk);
    #1;
    now            = cyc;
    mem_rdata_i    = prev_gnt ? mem_byte(prev_addr) : 8'($urandom);
    rst            = r;
    mem_grant_i    = g;
    stall_i        = s;
    flush_i        = f;
    flush_target_i = t;
    #1;
    s_req     = mem_req_o;
    s_addr    = mem_addr_o;
    prev_gnt  = g && mem_req_o;
    prev_addr = mem_addr_o;
    if (prev_gnt) begin
      chk("stream_addr", mem_addr_o, exp_addr);
      exp_addr = exp_addr + 32'd1;
    end
    if (r)      restart(32'h0000_0000);
    else if (f) restart(t);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // First cycle out of reset is cycle 0 of a directed case.
  task automatic release_rst(input logic g, input logic f, input logic [31:0] t);
    dlv_cyc.delete();
    cycle(1'b0, g, 1'b0, f, t);
    base = now;
  endtask

  // Monitor: every delivered word must be the next one of the current stream.
  always @(negedge clk) begin
    if (get_inst_o === 1'b1) begin
      exp_t e;
      dlv_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL unexpected_delivery pc=%h inst=%h", if_pc_o, if_inst_o);
      end else begin
        e = exp_q.pop_front();
        chk("dlv_pc", if_pc_o, e.pc);
        chk("dlv_inst", if_inst_o, e.inst);
        exp_q.push_back('{e.pc + 32'd4, word_at(e.pc + 32'd4)});
      end
    end
  end

  initial begin
    int hold_reqs;
    logic [31:0] c3_addr;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h00; mem[3] = 8'h00;
    mem[4] = 8'h93; mem[5] = 8'h05; mem[6] = 8'h10; mem[7] = 8'h00;

    // Reset values, then back-to-back fetch with the port always granted.
    do_reset();
    chk("rst_get_inst", 32'(get_inst_o), 32'd0);
    chk("rst_pc", if_pc_o, 32'd0);
    chk("rst_inst", if_inst_o, 32'd0);
    chk("rst_req", 32'(s_req), 32'd0);
    chk("rst_addr", s_addr, 32'd0);
    release_rst(1'b1, 1'b0, '0);
    chk("t1_first_req", 32'(s_req), 32'd1);
    for (int i = 1; i <= 11; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("t1_count", 32'(dlv_cyc.size()), 32'd2);
    chk("t1_first_cyc", 32'(dlv_rel(0)), 32'd5);
    chk("t1_second_cyc", 32'(dlv_rel(1)), 32'd10);
    chk("t1_last_pc", if_pc_o, 32'h0000_0004);
    chk("t1_last_inst", if_inst_o, 32'h0010_0593);

    // Grant withheld for 3 cycles after byte1 issued: delivery slips by 3.
    do_reset();
    release_rst(1'b1, 1'b0, '0);
    for (int i = 1; i <= 9; i++) cycle(1'b0, !(i >= 2 && i <= 4), 1'b0, 1'b0, '0);
    chk("t2_count", 32'(dlv_cyc.size()), 32'd1);
    chk("t2_cyc", 32'(dlv_rel(0)), 32'd8);
    chk("t2_inst", if_inst_o, 32'h0000_0513);

    // Stall across completion: hold quietly, deliver right after stall drops.
    do_reset();
    release_rst(1'b1, 1'b0, '0);
    hold_reqs = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 1'b1, (i >= 3 && i <= 8), 1'b0, '0);
      if (i >= 5 && i <= 8 && s_req) hold_reqs++;
    end
    chk("t3_hold_reqs", 32'(hold_reqs), 32'd0);
    chk("t3_count", 32'(dlv_cyc.size()), 32'd1);
    chk("t3_cyc", 32'(dlv_rel(0)), 32'd10);
    chk("t3_inst", if_inst_o, 32'h0000_0513);

    // Flush while byte2 is in flight: that byte is dropped, target refetched.
    do_reset();
    release_rst(1'b1, 1'b0, '0);
    c3_addr = '0;
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b0, 1'b1, 1'b0, (i == 2), 32'h0000_0100);
      if (i == 3) c3_addr = s_addr;
    end
    chk("t4_redirect_addr", c3_addr, 32'h0000_0100);
    chk("t4_count", 32'(dlv_cyc.size()), 32'd1);
    chk("t4_cyc", 32'(dlv_rel(0)), 32'd8);
    chk("t4_pc", if_pc_o, 32'h0000_0100);
    chk("t4_inst", if_inst_o, word_at(32'h0000_0100));

    // Flush and stall together on the completing cycle: nothing delivered.
    do_reset();
    release_rst(1'b1, 1'b0, '0);
    for (int i = 1; i <= 10; i++) cycle(1'b0, 1'b1, (i == 4), (i == 4), 32'h0000_0040);
    chk("t5_count", 32'(dlv_cyc.size()), 32'd1);
    chk("t5_cyc", 32'(dlv_rel(0)), 32'd10);
    chk("t5_pc", if_pc_o, 32'h0000_0040);

    // Reset with two bytes collected: start over from RESET_PC.
    do_reset();
    release_rst(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
    release_rst(1'b1, 1'b0, '0);
    chk("t6_req_addr", s_addr, 32'h0000_0000);
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("t6_count", 32'(dlv_cyc.size()), 32'd1);
    chk("t6_cyc", 32'(dlv_rel(0)), 32'd5);

    // PC wrap across the top of the address space.
    do_reset();
    release_rst(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 1; i <= 16; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("t7_count", 32'(dlv_cyc.size()), 32'd3);
    chk("t7_cyc", 32'(dlv_rel(2)), 32'd16);
    chk("t7_pc", if_pc_o, 32'h0000_0000);

    // Random grants, stalls, flushes and occasional resets.
    do_reset();
    release_rst(1'b1, 1'b0, '0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      case ($urandom_range(0, 9))
        0:       tgt = 32'hFFFF_FFF8;
        1:       tgt = 32'($urandom_range(0, 511));
        default: tgt = {23'd0, 7'($urandom_range(0, 127)), 2'b00};
      endcase
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 49) == 0), tgt);
    end
    nchk++;
    if (dlv_cyc.size() < 50) begin
      nerr++;
      $display("FAIL rand_progress got=%0d expected>=50", dlv_cyc.size());
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and reads each 32-bit instruction from the byte-wide unified memory port, one byte per granted cycle, little-endian.
- Emits one-cycle `get_inst_o` pulses with `if_pc_o`/`if_inst_o` into the IF/ID pipeline register, which inserts a bubble whenever `get_inst_o` is low.
- Redirected by branch/jump flushes from EX. Held by downstream stall.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- INST_BYTES, 4, bytes per instruction; fixed at 4 (RV32I, no compressed).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- stall_i  in  1  downstream cannot accept; hold the completed instruction
- flush_i  in  1  redirect (taken branch/jump); also drives IF/ID flush externally
- flush_target_i  in  32  new PC when flush_i=1
- mem_req_o  out  1  fetch requests the memory port this cycle
- mem_addr_o  out  32  byte address requested
- mem_grant_i  in  1  arbiter grants port this cycle; data returns next cycle
- mem_rdata_i  in  8  read byte, valid the cycle after a granted request
- get_inst_o  out  1  if_pc_o/if_inst_o valid this cycle (one pulse per instruction)
- if_pc_o  out  32  PC of delivered instruction
- if_inst_o  out  32  delivered instruction {b3,b2,b1,b0}

Behaviour:
- Reset (rst=1 at a posedge):
  - fetch_pc←RESET_PC, issue_cnt←0, recv_cnt←0, pending←0, state←FETCH.
  - get_inst_o←0, if_pc_o←0, if_inst_o←0, mem_req_o←0, mem_addr_o←0.
  - Reset mid-fetch abandons the fetch. A byte returning the cycle after reset is ignored.
- Memory protocol:
  - mem_req_o=1 and mem_addr_o=fetch_pc+issue_cnt while in FETCH with issue_cnt<4. These are combinational from registered state.
  - If mem_grant_i=1 in cycle t: issue_cnt++, pending←1. Byte arrives in t+1.
  - In any cycle with pending=1 (and no discard): byte[recv_cnt]←mem_rdata_i, recv_cnt++.
  - Issue and receive overlap. Best-case latency: request byte0 in cycle 0, get_inst_o=1 in cycle 5 (byte3 captured at end of cycle 4, outputs registered).
- Grant loss: issue_cnt holds. A byte already in flight is still captured. No re-request of captured bytes.
- States:
  - FETCH: collecting bytes.
    - When recv_cnt reaches 4 and stall_i=0: get_inst_o←1 for one cycle, outputs←(fetch_pc, assembled word), fetch_pc←fetch_pc+4, counters←0. Remain in FETCH; the next byte0 request is issued the following cycle.
    - When recv_cnt reaches 4 and stall_i=1: go to HOLD with get_inst_o=0.
  - HOLD: word retained, mem_req_o=0.
    - Leave on the first cycle with stall_i=0: deliver as above and return to FETCH.
- get_inst_o is low in every cycle without a delivery; IF/ID sees a bubble.
- Flush (priority over stall and over delivery in the same cycle):
  - fetch_pc←flush_target_i, counters←0, state←FETCH, get_inst_o←0.
  - A byte returning in the cycle after the flush (from a pre-flush grant) is discarded: discard flag set for one cycle.
  - Target byte0 is requested the cycle after the flush.
- flush_target_i[1:0]≠0 is not checked. Fetch proceeds at the given byte address.
- PC arithmetic is 32-bit; wraps 32'hFFFF_FFFC→0.
- fetch_pc+issue_cnt is computed 32-bit, no carry into other state.

Decomposition:
- Shared defines header (existing): RstEnable, ZeroWord, InstAddrBus (31:0), InstBus (31:0).
- Add to the header: state encodings IF_FETCH/IF_HOLD, and INST_BYTES.
- One natural sub-module: if_byte_asm, a 4×8 byte collector with recv_cnt, discard flag and 32-bit assembled output. The FSM, PC and request logic stay in if_fetch.

Test Plan:
- Reset, grant always 1, memory 0x00..0x07 = 13 05 00 00 93 05 10 00 → get_inst_o pulses at cycles 5 and 10; pc 0x0 inst 0x00000513, then pc 0x4 inst 0x00100593; outputs all 0 during reset.
- Grant low for 3 cycles after byte1 issued → byte1 still captured; get_inst_o delayed exactly 3 cycles; inst unchanged.
- stall_i=1 from cycle 3 to 8 → no pulse until stall drops; single pulse the cycle after stall_i falls, correct word; no memory requests while in HOLD.
- flush_i=1, target 0x100, while byte2 in flight → that byte discarded; next request addr 0x100; first delivered if_pc_o=0x100 with bytes from 0x100..0x103.
- flush_i and stall_i together in the cycle of completion → no delivery; refetch from target.
- rst asserted mid-fetch (recv_cnt=2) → next request addr RESET_PC; no pulse until 4 fresh bytes arrive.
